// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches one word per cycle into an in-order queue, hands words to decode.
// Latency: a word fetched in cycle N is presented to decode in cycle N+1 at the earliest (no bypass).
// Backpressure: out_ready low fills the queue; fetch stalls (PC holds) while full unless a pop frees a slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int            PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW:0]   FULL    = (PW + 1)'(QUEUE_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          pop;
  logic          push;

  // Target is word aligned; the low two bits of redirect_pc carry no meaning.
  logic [1:0] unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[1:0];

  assign inst_addr    = fetch_pc;
  assign out_valid    = (count != '0) & ~redirect;
  assign out_inst     = q_inst[rd_ptr];
  assign out_pc       = q_pc[rd_ptr];
  assign out_pc_plus4 = out_pc + 32'd4;

  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  assign pop  = out_valid & out_ready;
  assign push = ~redirect & ((count < FULL) | pop);

  // Occupancy update from the push/pop pair.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // PC, queue storage and pointers; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]   <= fetch_pc;
        q_inst[wr_ptr] <= inst_data;
        wr_ptr         <= wr_ptr + PTR_ONE;
        fetch_pc       <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a combinational instruction memory model.
// Two instances share stimulus; the second one starts near the top of the address space.
// Memory word at address A is A ^ KEY, so every expected instruction follows from its PC.
module tb_fetch_unit;

  localparam logic [31:0] KEY     = 32'h1357_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b0;

  logic [31:0] inst_addr, inst_data, out_inst, out_pc, out_pc_plus4;
  logic        out_valid;
  logic [31:0] inst_addr2, inst_data2, out_inst2, out_pc2, out_pc_plus42;
  logic        out_valid2;

  int tests = 0;
  int fails = 0;

  assign inst_data  = inst_addr ^ KEY;
  assign inst_data2 = inst_addr2 ^ KEY;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .QUEUE_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .inst_addr(inst_addr2), .inst_data(inst_data2),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid2),
    .out_ready(out_ready), .out_inst(out_inst2), .out_pc(out_pc2), .out_pc_plus4(out_pc_plus42)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold rst over one edge; return in the first cycle with rst low (cycle R+1).
  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = ready;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (inst_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 00000000", inst_addr); end
    tests++; if (out_inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h want 00000000", out_inst); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 00000000", out_pc); end
    tests++; if (out_pc_plus4 !== 32'h4) begin fails++; $display("FAIL reset_pc4 got %h want 00000004", out_pc_plus4); end
  endtask

  // out_ready high from reset: pcs 0,4,8,... one per cycle from R+2.
  task automatic test_stream();
    logic [31:0] exp;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      exp = 32'(i) * 32'd4;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
      tests++; if (out_pc !== exp) begin fails++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, exp); end
      tests++; if (out_inst !== (exp ^ KEY)) begin fails++; $display("FAIL stream_inst[%0d] got %h want %h", i, out_inst, exp ^ KEY); end
      tests++; if (out_pc_plus4 !== exp + 32'd4) begin fails++; $display("FAIL stream_pc4[%0d] got %h want %h", i, out_pc_plus4, exp + 32'd4); end
    end
  endtask

  // Ten stalled cycles fill the queue; release delivers 0..20 with no gap.
  task automatic test_backpressure();
    logic [31:0] exp;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step();
    tests++; if (inst_addr !== 32'h10) begin fails++; $display("FAIL bp_addr_hold got %h want 00000010", inst_addr); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b want 1", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL bp_pc_hold got %h want 00000000", out_pc); end
    tests++; if (out_inst !== KEY) begin fails++; $display("FAIL bp_inst_hold got %h want %h", out_inst, KEY); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = 32'(i) * 32'd4;
      tests++; if (out_valid !== 1'b1 || out_pc !== exp) begin
        fails++; $display("FAIL bp_drain[%0d] got valid=%b pc=%h want valid=1 pc=%h", i, out_valid, out_pc, exp);
      end
      step();
    end
  endtask

  // Redirect to 0x103 while full: bubble, then 0x100 onwards only.
  task automatic test_redirect_full();
    logic [31:0] exp;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_full_same_valid got %b want 0", out_valid); end
    step();
    redirect = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_full_n1_valid got %b want 0", out_valid); end
    tests++; if (inst_addr !== 32'h100) begin fails++; $display("FAIL redir_full_n1_addr got %h want 00000100", inst_addr); end
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'h100 + 32'(i) * 32'd4;
      tests++; if (out_valid !== 1'b1 || out_pc !== exp || out_inst !== (exp ^ KEY)) begin
        fails++; $display("FAIL redir_full_seq[%0d] got valid=%b pc=%h inst=%h want valid=1 pc=%h inst=%h",
                          i, out_valid, out_pc, out_inst, exp, exp ^ KEY);
      end
      step();
    end
  endtask

  // Redirect with out_ready high on a valid head: head dropped, queue empty next cycle.
  task automatic test_redirect_ready();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_rdy_same_valid got %b want 0", out_valid); end
    step();
    redirect = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_rdy_empty got %b want 0", out_valid); end
    tests++; if (inst_addr !== 32'h200) begin fails++; $display("FAIL redir_rdy_addr got %h want 00000200", inst_addr); end
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      fails++; $display("FAIL redir_rdy_target got valid=%b pc=%h want valid=1 pc=00000200", out_valid, out_pc);
    end
    step();
    tests++; if (out_pc !== 32'h204) begin fails++; $display("FAIL redir_rdy_next got %h want 00000204", out_pc); end
  endtask

  // rst with redirect mid-stream: reset wins, redirect_pc ignored.
  task automatic test_rst_mid();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    rst = 1'b0; redirect = 1'b0;
    tests++; if (inst_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_addr got %h want 00000000", inst_addr); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    tests++; if (out_pc !== 32'h0) begin fails++; $display("FAIL rst_mid_pc got %h want 00000000", out_pc); end
    step();
    tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      fails++; $display("FAIL rst_mid_restart got valid=%b pc=%h want valid=1 pc=00000000", out_valid, out_pc);
    end
  endtask

  // High reset PC wraps through zero.
  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_p4 [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_p4[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'hFFFF_FFFC; exp_p4[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0000; exp_p4[2] = 32'h0000_0004;
    do_reset(1'b1);
    tests++; if (inst_addr2 !== WRAP_PC) begin fails++; $display("FAIL wrap_reset_addr got %h want %h", inst_addr2, WRAP_PC); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (out_valid2 !== 1'b1 || out_pc2 !== exp_pc[i] || out_pc_plus42 !== exp_p4[i]) begin
        fails++; $display("FAIL wrap_seq[%0d] got valid=%b pc=%h pc4=%h want valid=1 pc=%h pc4=%h",
                          i, out_valid2, out_pc2, out_pc_plus42, exp_pc[i], exp_p4[i]);
      end
      tests++; if (out_inst2 !== (exp_pc[i] ^ KEY)) begin
        fails++; $display("FAIL wrap_inst[%0d] got %h want %h", i, out_inst2, exp_pc[i] ^ KEY);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_ready();
    test_rst_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
